sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It is the next generation of the team's 8x8 FIFO, generalised in data width and depth. It adds programmable almost-full/almost-empty thresholds, a registered read-valid strobe, sticky overflow/underflow error flags and defined simultaneous read/write behaviour. It sits between single-clock-domain producers and consumers, such as the UART and DMA staging paths.

---
 rtl/sync_fifo_param.sv | 113 +++++++++++
 tb/tb_sync_fifo_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy flags
// computed from the next-state count, and sticky overflow/underflow errors.
module sync_fifo_param #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AFULL_TH  = DEPTH - 2,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [DATA_W-1:0]           data_in,
   input  logic                        rd_en,
   input  logic                        clr_err,
   output logic [DATA_W-1:0]           data_out,
   output logic                        rd_valid,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        is_full,
   output logic                        is_empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_acc;
   logic              rd_acc;
   logic [CW-1:0]     count_nxt;

   // Acceptance qualifiers and next occupancy; flags come from the registered
   // is_full/is_empty so there is no path from the requests to the flag outputs.
   always_comb begin
      wr_acc    = wr_en & ~is_full;
      rd_acc    = rd_en & ~is_empty;
      count_nxt = count;
      if (wr_acc && !rd_acc) begin
         count_nxt = count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count - CW'(1);
      end
   end

   // Storage array; deliberately not reset, only written entries are ever read.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers, occupancy and flags registered from the next-state count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         is_full      <= 1'b0;
         is_empty     <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count        <= count_nxt;
         is_full      <= (count_nxt == CW'(DEPTH));
         is_empty     <= (count_nxt == CW'(0));
         almost_full  <= (count_nxt >= CW'(AFULL_TH));
         almost_empty <= (count_nxt <= CW'(AEMPTY_TH));
      end
   end

   // Registered read port with a one-cycle valid strobe; refused reads hold data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            data_out <= mem[rd_ptr];
         end
      end
   end

   // Sticky error flags; a new error event in the same cycle beats clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && is_full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_en && is_empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] data_in;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] data_out;
   logic       rd_valid;
   logic [3:0] count;
   logic       is_full;
   logic       is_empty;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       underflow;

   int checks_total  = 0;
   int checks_passed = 0;

   sync_fifo_param #(
      .DATA_W    (8),
      .DEPTH     (8),
      .AFULL_TH  (6),
      .AEMPTY_TH (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .count        (count),
      .is_full      (is_full),
      .is_empty     (is_empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // One comparison: count it, and report any disagreement.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
      tick(); tick();

      // Reset state
      check("rst_count",        32'(count),        32'd0);
      check("rst_is_empty",     32'(is_empty),     32'd1);
      check("rst_is_full",      32'(is_full),      32'd0);
      check("rst_almost_empty", 32'(almost_empty), 32'd1);
      check("rst_almost_full",  32'(almost_full),  32'd0);
      check("rst_data_out",     32'(data_out),     32'd0);
      check("rst_rd_valid",     32'(rd_valid),     32'd0);
      check("rst_overflow",     32'(overflow),     32'd0);
      check("rst_underflow",    32'(underflow),    32'd0);
      rst = 1'b0;
      tick();

      // 1: fill with 0x11..0x18
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 8'(8'h11 + i);
         tick();
         check("fill_count",        32'(count),        32'(i + 1));
         check("fill_almost_empty", 32'(almost_empty), 32'(i + 1 <= 2));
         check("fill_almost_full",  32'(almost_full),  32'(i + 1 >= 6));
         check("fill_is_full",      32'(is_full),      32'(i == 7));
         check("fill_is_empty",     32'(is_empty),     32'd0);
      end
      wr_en = 1'b0;
      check("fill_overflow", 32'(overflow), 32'd0);

      // 2: write while full is dropped, then drain in order
      wr_en = 1'b1; data_in = 8'hAA;
      tick();
      wr_en = 1'b0;
      check("ovf_flag",  32'(overflow), 32'd1);
      check("ovf_count", 32'(count),    32'd8);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 7) rd_en = 1'b0;
         check("drain_data",  32'(data_out), 32'h11 + 32'(i));
         check("drain_valid", 32'(rd_valid), 32'd1);
         check("drain_count", 32'(count),    32'(7 - i));
      end
      check("drain_is_empty",  32'(is_empty),  32'd1);
      check("drain_underflow", 32'(underflow), 32'd0);
      tick();
      check("drain_valid_low", 32'(rd_valid), 32'd0);

      // 3: read while empty, clear, and set-wins-over-clear
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("udf_flag",     32'(underflow), 32'd1);
      check("udf_rd_valid", 32'(rd_valid),  32'd0);
      check("udf_data_out", 32'(data_out),  32'h18);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_underflow", 32'(underflow), 32'd0);
      check("clr_overflow",  32'(overflow),  32'd0);
      rd_en = 1'b1; clr_err = 1'b1;
      tick();
      rd_en = 1'b0; clr_err = 1'b0;
      check("set_wins_underflow", 32'(underflow), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // 4: preload 4, then 20 cycles of simultaneous read/write across wraps
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; data_in = 8'(8'h30 + i);
         tick();
      end
      check("pre_count", 32'(count), 32'd4);
      rd_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_in = 8'(8'h34 + i);
         tick();
         check("rw_count", 32'(count),    32'd4);
         check("rw_data",  32'(data_out), 32'h30 + 32'(i));
         check("rw_valid", 32'(rd_valid), 32'd1);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) rd_en = 1'b0;
         check("rw_tail_data", 32'(data_out), 32'h44 + 32'(i));
      end
      check("rw_is_empty",  32'(is_empty),  32'd1);
      check("rw_overflow",  32'(overflow),  32'd0);
      check("rw_underflow", 32'(underflow), 32'd0);

      // 5: simultaneous read/write on empty, no fall-through
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h5C;
      tick();
      wr_en = 1'b0;
      check("emp_rw_underflow", 32'(underflow), 32'd1);
      check("emp_rw_count",     32'(count),     32'd1);
      check("emp_rw_valid",     32'(rd_valid),  32'd0);
      check("emp_rw_data_hold", 32'(data_out),  32'h47);
      tick();
      rd_en = 1'b0;
      check("emp_rw_read_data",  32'(data_out), 32'h5C);
      check("emp_rw_read_valid", 32'(rd_valid), 32'd1);
      check("emp_rw_read_count", 32'(count),    32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // 6: reset mid-stream with 5 words stored
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = 8'(8'h60 + i);
         tick();
      end
      wr_en = 1'b0;
      check("pre_rst_count", 32'(count), 32'd5);
      rst = 1'b1;
      #1;
      check("mid_rst_count",        32'(count),        32'd0);
      check("mid_rst_is_empty",     32'(is_empty),     32'd1);
      check("mid_rst_almost_empty", 32'(almost_empty), 32'd1);
      check("mid_rst_data_out",     32'(data_out),     32'd0);
      check("mid_rst_rd_valid",     32'(rd_valid),     32'd0);
      tick();
      rst = 1'b0;
      wr_en = 1'b1; data_in = 8'h77;
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("post_rst_data",  32'(data_out), 32'h77);
      check("post_rst_valid", 32'(rd_valid), 32'd1);
      check("post_rst_count", 32'(count),    32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
